// File: rtl/sdrc_bus_width_conv.sv
// App <-> SDRAM data-width converter: splits app words into 1/2/4/8 beats and packs read beats back.
// Optional macro SDRC_WCONV_RDREG_EN registers the read outputs (+1 cycle read latency).
module sdrc_bus_width_conv #(
    parameter int APP_DW = 32,
    parameter int CW     = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            sdr_width,
    input  logic [APP_DW-1:0]     app_wr_data,
    input  logic [APP_DW/8-1:0]   app_wr_en_n,
    output logic                  app_wr_next,
    output logic [APP_DW-1:0]     a2x_wrdt,
    output logic [APP_DW/8-1:0]   a2x_wren_n,
    input  logic                  x2a_wrnext,
    input  logic                  x2a_wrlast,
    input  logic [APP_DW-1:0]     x2a_rddt,
    input  logic                  x2a_rdok,
    input  logic                  x2a_rdlast,
    output logic [APP_DW-1:0]     app_rd_data,
    output logic                  app_rd_valid,
    output logic                  app_rd_partial,
    output logic                  wr_trunc,
    output logic [CW-1:0]         wr_xfr_count,
    output logic [CW-1:0]         rd_xfr_count
);

    localparam int NB = APP_DW / 8;

    logic [1:0]        r_width;
    logic [CW-1:0]     r_wr_cnt;
    logic [CW-1:0]     r_rd_cnt;
    logic [APP_DW-1:0] r_saved;

    logic [1:0]        w_log2n;
    logic [CW-1:0]     w_last;
    logic [9:0]        w_lane_w;
    logic [9:0]        w_lane_b;
    logic [9:0]        w_wr_sh;
    logic [9:0]        w_wr_shb;
    logic [9:0]        w_rd_sh;
    logic [APP_DW-1:0] w_dmask;
    logic [NB-1:0]     w_bmask;
    logic              w_wchg;
    logic              w_act;
    logic              w_wr_end;
    logic              w_rd_end;
    logic [APP_DW-1:0] w_rd_merged;
    logic              w_rd_valid;
    logic              w_rd_partial;

    // A 32-bit app word cannot be split into 8 beats, so 1/8 falls back to 1/4.
    always_comb begin
        w_log2n = 2'd0;
        w_last  = '0;
        case (sdr_width)
            2'b00: begin w_log2n = 2'd0; w_last = CW'(0); end
            2'b01: begin w_log2n = 2'd1; w_last = CW'(1); end
            2'b10: begin w_log2n = 2'd2; w_last = CW'(3); end
            default: begin
                if (APP_DW == 32) begin
                    w_log2n = 2'd2; w_last = CW'(3);
                end else begin
                    w_log2n = 2'd3; w_last = CW'(7);
                end
            end
        endcase
    end

    assign w_lane_w = 10'(APP_DW) >> w_log2n;
    assign w_lane_b = w_lane_w >> 3;
    assign w_wr_sh  = w_lane_w * 10'(r_wr_cnt);
    assign w_wr_shb = w_lane_b * 10'(r_wr_cnt);
    assign w_rd_sh  = w_lane_w * 10'(r_rd_cnt);
    assign w_dmask  = ~({APP_DW{1'b1}} << w_lane_w);
    assign w_bmask  = ~({NB{1'b1}} << w_lane_b);

    // Beats arriving in the cycle a width change is detected belong to a dropped word.
    assign w_wchg   = (sdr_width != r_width);
    assign w_act    = !reset && !w_wchg;

    assign a2x_wrdt   = (app_wr_data >> w_wr_sh) & w_dmask;
    assign a2x_wren_n = (app_wr_en_n >> w_wr_shb) | ~w_bmask;

    assign w_wr_end    = (r_wr_cnt == w_last);
    assign app_wr_next = w_act && x2a_wrnext && (w_wr_end || x2a_wrlast);
    assign wr_trunc    = w_act && x2a_wrnext && x2a_wrlast && !w_wr_end;

    assign w_rd_end     = (r_rd_cnt == w_last);
    assign w_rd_merged  = r_saved | ((x2a_rddt & w_dmask) << w_rd_sh);
    assign w_rd_valid   = w_act && x2a_rdok && (w_rd_end || x2a_rdlast);
    assign w_rd_partial = w_rd_valid && x2a_rdlast && !w_rd_end;

    assign wr_xfr_count = r_wr_cnt;
    assign rd_xfr_count = r_rd_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_width  <= 2'b00;
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
            r_saved  <= '0;
        end else begin
            r_width <= sdr_width;
            if (w_wchg) begin
                r_wr_cnt <= '0;
                r_rd_cnt <= '0;
                r_saved  <= '0;
            end else begin
                if (x2a_wrnext) begin
                    if (w_wr_end || x2a_wrlast) r_wr_cnt <= '0;
                    else                        r_wr_cnt <= r_wr_cnt + CW'(1);
                end
                if (x2a_rdok) begin
                    if (w_rd_end || x2a_rdlast) begin
                        r_rd_cnt <= '0;
                        r_saved  <= '0;
                    end else begin
                        r_rd_cnt <= r_rd_cnt + CW'(1);
                        r_saved  <= w_rd_merged;
                    end
                end
            end
        end
    end

`ifdef SDRC_WCONV_RDREG_EN
    logic [APP_DW-1:0] r_rd_data_p1;
    logic              r_rd_valid_p1;
    logic              r_rd_partial_p1;

    // Read output stage p1
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_data_p1    <= '0;
            r_rd_valid_p1   <= 1'b0;
            r_rd_partial_p1 <= 1'b0;
        end else begin
            r_rd_data_p1    <= w_rd_merged;
            r_rd_valid_p1   <= w_rd_valid;
            r_rd_partial_p1 <= w_rd_partial;
        end
    end

    assign app_rd_data    = r_rd_data_p1;
    assign app_rd_valid   = r_rd_valid_p1;
    assign app_rd_partial = r_rd_partial_p1;
`else
    assign app_rd_data    = w_rd_merged;
    assign app_rd_valid   = w_rd_valid;
    assign app_rd_partial = w_rd_partial;
`endif

endmodule

// File: tb/tb_sdrc_bus_width_conv.sv
// Directed bench for sdrc_bus_width_conv: a 32-bit and a 64-bit instance share one stimulus stream.
module tb_sdrc_bus_width_conv;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  sdr_width;
    logic [63:0] wr_data;
    logic [7:0]  wr_en_n;
    logic        wrnext, wrlast;
    logic [63:0] rddt;
    logic        rdok, rdlast;

    logic        app_wr_next32, app_rd_valid32, app_rd_partial32, wr_trunc32;
    logic [31:0] a2x_wrdt32, app_rd_data32;
    logic [3:0]  a2x_wren_n32;
    logic [2:0]  wr_cnt32, rd_cnt32;

    logic        app_wr_next64, app_rd_valid64, app_rd_partial64, wr_trunc64;
    logic [63:0] a2x_wrdt64, app_rd_data64;
    logic [7:0]  a2x_wren_n64;
    logic [2:0]  wr_cnt64, rd_cnt64;

    int ncmp = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    sdrc_bus_width_conv #(.APP_DW(32), .CW(3)) u_dut32 (
        .clk(clk), .reset(reset), .sdr_width(sdr_width),
        .app_wr_data(wr_data[31:0]), .app_wr_en_n(wr_en_n[3:0]), .app_wr_next(app_wr_next32),
        .a2x_wrdt(a2x_wrdt32), .a2x_wren_n(a2x_wren_n32),
        .x2a_wrnext(wrnext), .x2a_wrlast(wrlast),
        .x2a_rddt(rddt[31:0]), .x2a_rdok(rdok), .x2a_rdlast(rdlast),
        .app_rd_data(app_rd_data32), .app_rd_valid(app_rd_valid32), .app_rd_partial(app_rd_partial32),
        .wr_trunc(wr_trunc32), .wr_xfr_count(wr_cnt32), .rd_xfr_count(rd_cnt32)
    );

    sdrc_bus_width_conv #(.APP_DW(64), .CW(3)) u_dut64 (
        .clk(clk), .reset(reset), .sdr_width(sdr_width),
        .app_wr_data(wr_data), .app_wr_en_n(wr_en_n), .app_wr_next(app_wr_next64),
        .a2x_wrdt(a2x_wrdt64), .a2x_wren_n(a2x_wren_n64),
        .x2a_wrnext(wrnext), .x2a_wrlast(wrlast),
        .x2a_rddt(rddt), .x2a_rdok(rdok), .x2a_rdlast(rdlast),
        .app_rd_data(app_rd_data64), .app_rd_valid(app_rd_valid64), .app_rd_partial(app_rd_partial64),
        .wr_trunc(wr_trunc64), .wr_xfr_count(wr_cnt64), .rd_xfr_count(rd_cnt64)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Read outputs of the 32-bit instance; registered build shows them after the edge.
    task automatic rchk(input string tag, input logic v, input logic p, input logic [31:0] d);
`ifdef SDRC_WCONV_RDREG_EN
        @(posedge clk);
        #1;
`endif
        chk({tag, "_valid"}, 64'(app_rd_valid32), 64'(v));
        chk({tag, "_partial"}, 64'(app_rd_partial32), 64'(p));
        if (v) chk({tag, "_data"}, 64'(app_rd_data32), 64'(d));
    endtask

    logic [31:0] t3_beats [4] = '{32'h11, 32'h22, 32'h33, 32'h44};

    initial begin
        reset = 1'b1; sdr_width = 2'b00; wr_data = '0; wr_en_n = 8'hFF;
        wrnext = 1'b0; wrlast = 1'b0; rddt = '0; rdok = 1'b0; rdlast = 1'b0;

        // reset: strobes in reset must produce no pulses
        @(negedge clk);
        wr_data = 64'hDEADBEEF; wrnext = 1'b1; rdok = 1'b1; rdlast = 1'b1; rddt = 64'h1;
        #1;
        chk("rst_wrnext", 64'(app_wr_next32), 64'd0);
        chk("rst_trunc", 64'(wr_trunc32), 64'd0);
        chk("rst_wrdt", 64'(a2x_wrdt32), 64'hDEADBEEF);
        rchk("rst_rd", 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        reset = 1'b0; wrnext = 1'b0; rdok = 1'b0; rdlast = 1'b0;
        #1;
        chk("rst_wcnt", 64'(wr_cnt32), 64'd0);
        chk("rst_rcnt", 64'(rd_cnt32), 64'd0);

        // test 1: full width pass-through write
        @(negedge clk);
        wrnext = 1'b1; #1;
        chk("t1_wrdt", 64'(a2x_wrdt32), 64'hDEADBEEF);
        chk("t1_wrnext", 64'(app_wr_next32), 64'd1);
        chk("t1_cnt", 64'(wr_cnt32), 64'd0);
        @(negedge clk);
        wrnext = 1'b0; #1;
        chk("t1_cnt_after", 64'(wr_cnt32), 64'd0);

        // test 2: half width write
        @(negedge clk);
        sdr_width = 2'b01; #1;
        @(negedge clk);
        wr_data = 64'h12345678; wr_en_n = 8'hF9; wrnext = 1'b1; #1;
        chk("t2_b0_wrdt", 64'(a2x_wrdt32), 64'h5678);
        chk("t2_b0_wren", 64'(a2x_wren_n32), 64'hD);
        chk("t2_b0_wrnext", 64'(app_wr_next32), 64'd0);
        chk("t2_b0_cnt", 64'(wr_cnt32), 64'd0);
        @(negedge clk);
        #1;
        chk("t2_b1_wrdt", 64'(a2x_wrdt32), 64'h1234);
        chk("t2_b1_wren", 64'(a2x_wren_n32), 64'hE);
        chk("t2_b1_wrnext", 64'(app_wr_next32), 64'd1);
        chk("t2_b1_cnt", 64'(wr_cnt32), 64'd1);
        @(negedge clk);
        wrnext = 1'b0; #1;
        chk("t2_cnt_wrap", 64'(wr_cnt32), 64'd0);

        // test 3: quarter width read, four beats
        @(negedge clk);
        sdr_width = 2'b10; #1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rddt = 64'(t3_beats[i]); rdok = 1'b1; #1;
            rchk($sformatf("t3_b%0d", i), (i == 3), 1'b0, 32'h44332211);
        end
        @(negedge clk);
        rdok = 1'b0; #1;
        chk("t3_rcnt", 64'(rd_cnt32), 64'd0);
        rchk("t3_idle", 1'b0, 1'b0, 32'h0);

        // test 4: quarter width read truncated by rdlast
        @(negedge clk);
        rddt = 64'hAA; rdok = 1'b1; #1;
        rchk("t4_b0", 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        rddt = 64'hBB; rdlast = 1'b1; #1;
        rchk("t4_b1", 1'b1, 1'b1, 32'h0000BBAA);
        @(negedge clk);
        rdok = 1'b0; rdlast = 1'b0; #1;
        chk("t4_rcnt", 64'(rd_cnt32), 64'd0);

        // test 5: 1/8 width on the 64-bit instance, write burst ends on beat 3
        @(negedge clk);
        sdr_width = 2'b11; wr_data = 64'h0807060504030201; wr_en_n = 8'h00; #1;
        @(negedge clk);
        wrnext = 1'b1; #1;
        chk("t5_b0_wrdt", a2x_wrdt64, 64'h01);
        chk("t5_b0_wren", 64'(a2x_wren_n64), 64'hFE);
        chk("t5_b0_wrnext", 64'(app_wr_next64), 64'd0);
        @(negedge clk);
        #1;
        chk("t5_b1_wrdt", a2x_wrdt64, 64'h02);
        chk("t5_b1_cnt", 64'(wr_cnt64), 64'd1);
        @(negedge clk);
        wrlast = 1'b1; #1;
        chk("t5_b2_wrdt", a2x_wrdt64, 64'h03);
        chk("t5_b2_wrnext", 64'(app_wr_next64), 64'd1);
        chk("t5_b2_trunc", 64'(wr_trunc64), 64'd1);
        chk("t5_b2_wrdt32", 64'(a2x_wrdt32), 64'h03);
        chk("t5_b2_trunc32", 64'(wr_trunc32), 64'd1);
        @(negedge clk);
        wrnext = 1'b0; wrlast = 1'b0; #1;
        chk("t5_cnt_clr", 64'(wr_cnt64), 64'd0);
        chk("t5_trunc_idle", 64'(wr_trunc64), 64'd0);

        // wrlast without wrnext is ignored
        @(negedge clk);
        wrnext = 1'b1; #1;
        @(negedge clk);
        wrnext = 1'b0; wrlast = 1'b1; #1;
        chk("t5x_trunc", 64'(wr_trunc64), 64'd0);
        chk("t5x_wrnext", 64'(app_wr_next64), 64'd0);
        @(negedge clk);
        wrlast = 1'b0; #1;
        chk("t5x_cnt", 64'(wr_cnt64), 64'd1);

        // test 6: width change mid-word drops the partial word
        @(negedge clk);
        sdr_width = 2'b10; #1;
        @(negedge clk);
        rddt = 64'h55; rdok = 1'b1; #1;
        rchk("t6_b0", 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        rdok = 1'b0; sdr_width = 2'b01; #1;
        chk("t6_cnt_before", 64'(rd_cnt32), 64'd1);
        @(negedge clk);
        #1;
        chk("t6_cnt_clr", 64'(rd_cnt32), 64'd0);
        @(negedge clk);
        rddt = 64'hBEEF; rdok = 1'b1; #1;
        rchk("t6_b1", 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        rddt = 64'hCAFE; #1;
        rchk("t6_b2", 1'b1, 1'b0, 32'hCAFEBEEF);
        @(negedge clk);
        rdok = 1'b0; #1;

        // full width read is a single-beat pass-through
        @(negedge clk);
        sdr_width = 2'b00; #1;
        @(negedge clk);
        rddt = 64'hDEADBEEF; rdok = 1'b1; #1;
        chk("t7_rcnt", 64'(rd_cnt32), 64'd0);
        rchk("t7", 1'b1, 1'b0, 32'hDEADBEEF);
        @(negedge clk);
        rdok = 1'b0; #1;
        chk("t7_rcnt_after", 64'(rd_cnt32), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
